// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry front end and the adder/decoder datapath.
package operand_entry_pkg;

    localparam int OE_WIDTH           = 4;
    localparam int OE_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_DONE  = 2'd2
    } oe_state_t;

endpackage

// File: rtl/operand_entry_button_debouncer.sv
// Button conditioning: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle pulse on each accepted rising level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer; only sync[1] is used downstream.
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], btn_raw};
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples;
    // any sample matching deb restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            deb_q <= deb;
            if (sync[1] != deb) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign btn_level = deb;
    assign btn_press = deb & ~deb_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry: two load presses capture the switches into A then B; clear
// (which beats a simultaneous load) zeroes both and returns to IDLE.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = OE_WIDTH,
    parameter int DEBOUNCE_CYCLES = OE_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic             operands_valid,
    output logic [1:0]       state
);

    logic [WIDTH-1:0] sw_s1, sw_s2;
    logic             load_press, clear_press;
    logic             load_level, clear_level;
    logic             unused_levels;

    oe_state_t        state_q, state_d;
    logic [WIDTH-1:0] in1_d, in2_d;
    logic             valid_d;

    // Switch synchronizer; the switches are assumed to settle well before a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_load),
        .btn_level (load_level),
        .btn_press (load_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_clear),
        .btn_level (clear_level),
        .btn_press (clear_press)
    );

    // Debounced levels are not needed here; only the press pulses drive the FSM.
    assign unused_levels = load_level ^ clear_level;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            input1         <= '0;
            input2         <= '0;
            operands_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            input1         <= in1_d;
            input2         <= in2_d;
            operands_valid <= valid_d;
        end
    end

    // Next state: clear dominates; encoding 3 falls back to IDLE.
    always_comb begin
        state_d = state_q;
        if (clear_press) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (load_press) state_d = ST_GOT_A;
                ST_GOT_A: if (load_press) state_d = ST_DONE;
                ST_DONE:  if (load_press) state_d = ST_GOT_A;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next operand values; a load from IDLE or DONE starts a fresh entry with B zeroed.
    always_comb begin
        in1_d = input1;
        in2_d = input2;
        if (clear_press) begin
            in1_d = '0;
            in2_d = '0;
        end else if (load_press) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    in1_d = sw_s2;
                    in2_d = '0;
                end
                ST_GOT_A: in2_d = sw_s2;
                default: ;
            endcase
        end
        valid_d = (state_d == ST_DONE);
    end

    assign state = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a cycle-level behavioural model.
module tb_operand_entry;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw;
    logic         btn_load;
    logic         btn_clear;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         operands_valid;
    logic [1:0]   state;

    int n_checks = 0;
    int n_fail   = 0;

    operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .btn_load       (btn_load),
        .btn_clear      (btn_clear),
        .input1         (input1),
        .input2         (input2),
        .operands_valid (operands_valid),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // Each raw button is seen two edges late; it becomes the debounced level once
    // it has disagreed with it for DC edges in a row. A press is a 0->1 step of the
    // debounced level, acted on one edge later. The entry is tracked as the number
    // of operands captured so far (0, 1 or 2).
    bit           m_init = 0;
    bit           m_raw1[2], m_raw2[2], m_deb[2], m_debp[2];
    int           m_run[2];
    logic [W-1:0] m_sw1, m_sw2, m_a, m_b;
    int           m_cap;

    initial begin
        bit pl, pc;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_init = 1;
                for (int i = 0; i < 2; i++) begin
                    m_raw1[i] = 0; m_raw2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_run[i] = 0;
                end
                m_sw1 = '0; m_sw2 = '0; m_a = '0; m_b = '0; m_cap = 0;
            end else begin
                pl = m_deb[0] && !m_debp[0];
                pc = m_deb[1] && !m_debp[1];
                if (pc) begin
                    m_cap = 0; m_a = '0; m_b = '0;
                end else if (pl) begin
                    if (m_cap == 1) begin
                        m_b = m_sw2; m_cap = 2;
                    end else begin
                        m_a = m_sw2; m_b = '0; m_cap = 1;
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    m_debp[i] = m_deb[i];
                    if (m_raw2[i] != m_deb[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == DC) begin
                            m_deb[i] = m_raw2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_raw2[i] = m_raw1[i];
                end
                m_raw1[0] = btn_load;
                m_raw1[1] = btn_clear;
                m_sw2 = m_sw1;
                m_sw1 = sw;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_input1", input1, m_a);
            chk("model_input2", input2, m_b);
            chk("model_state", state, m_cap);
            chk("model_valid", operands_valid, m_cap == 2);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; sw = '0; btn_load = 1'b0; btn_clear = 1'b0;
        tick(2);
        chk("reset_input1", input1, 0);
        chk("reset_input2", input2, 0);
        chk("reset_valid", operands_valid, 0);
        chk("reset_state", state, 0);

        // First entry: load held clean from edge 0.
        rst = 1'b0; sw = 4'd5; btn_load = 1'b1;
        tick(6);
        chk("first_before_edge6_state", state, 0);
        tick(1);
        chk("first_input1", input1, 5);
        chk("first_state", state, 1);
        chk("first_valid", operands_valid, 0);
        btn_load = 1'b0;
        tick(12);
        chk("release_no_effect_state", state, 1);

        // Second press completes the entry.
        sw = 4'd9; btn_load = 1'b1;
        tick(7);
        chk("full_input1", input1, 5);
        chk("full_input2", input2, 9);
        chk("full_state", state, 2);
        chk("full_valid", operands_valid, 1);
        tick(10);
        btn_load = 1'b0;
        tick(20);
        chk("hold_input2", input2, 9);
        chk("hold_valid", operands_valid, 1);

        // Re-entry from DONE.
        sw = 4'd3; btn_load = 1'b1;
        tick(6);
        chk("reentry_valid_before", operands_valid, 1);
        tick(1);
        chk("reentry_input1", input1, 3);
        chk("reentry_input2", input2, 0);
        chk("reentry_state", state, 1);
        chk("reentry_valid", operands_valid, 0);
        btn_load = 1'b0;
        tick(12);

        // Bounce: 1,0,1,0 on alternate cycles, then stable high.
        sw = 4'd7;
        btn_load = 1'b1; tick(1);
        btn_load = 1'b0; tick(1);
        btn_load = 1'b1; tick(1);
        btn_load = 1'b0; tick(1);
        btn_load = 1'b1;
        tick(6);
        chk("bounce_early_state", state, 1);
        tick(1);
        chk("bounce_input2", input2, 7);
        chk("bounce_state", state, 2);
        btn_load = 1'b0;
        tick(12);

        // Three-cycle glitch is rejected.
        btn_load = 1'b1; tick(3);
        btn_load = 1'b0; tick(15);
        chk("glitch_state", state, 2);
        chk("glitch_input1", input1, 3);

        // Back to GOT_A, then simultaneous load and clear.
        sw = 4'd5; btn_load = 1'b1; tick(7);
        btn_load = 1'b0; tick(12);
        chk("pre_clear_state", state, 1);
        sw = 4'd10; btn_load = 1'b1; btn_clear = 1'b1;
        tick(7);
        chk("clear_state", state, 0);
        chk("clear_input1", input1, 0);
        chk("clear_input2", input2, 0);
        chk("clear_valid", operands_valid, 0);
        btn_load = 1'b0; btn_clear = 1'b0;
        tick(12);

        // Reset while the load debounce counter is at 2 in GOT_A.
        sw = 4'd6; btn_load = 1'b1; tick(7);
        btn_load = 1'b0; tick(12);
        chk("pre_reset_state", state, 1);
        btn_load = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midreset_input1", input1, 0);
        chk("midreset_input2", input2, 0);
        chk("midreset_state", state, 0);
        chk("midreset_valid", operands_valid, 0);
        rst = 1'b0;
        tick(6);
        chk("post_reset_early_state", state, 0);
        tick(1);
        chk("post_reset_input1", input1, 6);
        chk("post_reset_state", state, 1);
        tick(20);
        chk("post_reset_single_pulse", state, 1);
        btn_load = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
